gpc215_arbiter: RTL and testbench
=================================

// Module: gpc215_arbiter
// PURPOSE
//  Shares one combinational gpc215_4 counter (5 weight-1, 1 weight-2 and 2 weight-4
//  inputs; 4-bit sum out) between NUM_REQ requesters under round-robin arbitration.
//  Each requester presents one operand set with a valid/ready handshake. The block
//  registers the sum together with the winning requester's id and delivers it on a
//  valid/ready result port. Sits between the compressor-tree feeders and the
//  result-collection logic.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  ID_W     2  width of res_id; must equal clog2(NUM_REQ)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  req_valid  in   NUM_REQ    per-requester operand valid
//  req_ready  out  NUM_REQ    per-requester accept; at most one bit high
//  req_src0   in   NUM_REQ*5  weight-1 bits; requester i at [5i+4:5i]
//  req_src1   in   NUM_REQ    weight-2 bit; requester i at [i]
//  req_src2   in   NUM_REQ*2  weight-4 bits; requester i at [2i+1:2i]
//  res_valid  out  1          result register holds a valid sum
//  res_ready  in   1          downstream accepts the result
//  res_dst    out  4          sum = popcount(src0) + 2*src1 + 4*popcount(src2), range 0..15
//  res_id     out  ID_W       index of the requester that produced res_dst
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-low.
//  - Reset values: res_valid=0, res_dst=0, res_id=0, round-robin pointer ptr=0.
//    req_ready is all-zero while rst_n=0.
//  - can_accept = !res_valid | res_ready. The single result register drains and
//    refills in the same cycle, so full throughput is one result per cycle.
//  - Grant g: the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
//    The grant is combinational.
//  - req_ready[g] = can_accept & req_valid[g]. All other req_ready bits are 0.
//    req_ready is never high for a requester whose req_valid is low.
//  - Transfer on req_valid[g] & req_ready[g]. At the next edge:
//    - res_dst <= gpc(operands of g); res_id <= g; res_valid <= 1;
//    - ptr <= (g+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0).
//  - Operand mux: the muxed operands of g drive one gpc215_4 instance. Its dst is
//    4 bits and never overflows, because the maximum is 5+2+8 = 15.
//  - Latency: exactly 1 cycle from request transfer to res_valid.
//  - Draining: res_valid & res_ready with no new transfer -> res_valid <= 0 next
//    edge. res_dst and res_id keep their last values.
//  - Backpressure: res_valid & !res_ready -> no grant, ptr holds.
//    res_dst and res_id are held stable until accepted.
//  - Requester rule: operands must stay stable while req_valid=1 and req_ready=0.
//    A requester may drop req_valid before it is accepted. The arbiter then
//    re-evaluates the grant in the same cycle, with no penalty.
//  - No requests: ptr holds and no transfer occurs.
//  - Fairness: a requester holding req_valid is granted within NUM_REQ transfers.
//  - Reset asserted mid-operation: any pending result is discarded immediately
//    and outputs return to their reset values. No transfer completes on the
//    edge at which rst_n rises.
//  - No internal state besides the result register and ptr. There is no FSM
//    beyond EMPTY/FULL, which is encoded by res_valid.
// TESTING
//  1. Single request: req0 src0=5'h14, src1=1, src2=2'h1, res_ready=1.
//     -> next cycle res_valid=1, res_dst=4'h8, res_id=0. Then res_valid=0.
//  2. Arithmetic extremes via req2: src0=5'h1f, src1=1, src2=2'h3 -> res_dst=4'hf.
//     src0=0, src1=0, src2=0 -> res_dst=0.
//  3. All four requesters valid continuously, res_ready=1, ptr=0.
//     -> res_id sequence 0,1,2,3,0, one result per cycle.
//     Each req_ready pulses once per 4 cycles.
//  4. Backpressure: req1 src0=5'h0d, src2=2'h3 transferred, res_ready=0 for 3 cycles.
//     -> res_dst=4'hb, res_id=1 held. All req_ready=0 during the stall.
//     On release the next grant follows ptr=2.
//  5. Wrap and skip: only req3 and req1 valid, ptr=2.
//     -> grant 3 then 1, ptr ends at 2. Idle cycles leave ptr unchanged.
//  6. Reset while res_valid=1 and req_valid all high.
//     -> res_valid=0, res_dst=0, res_id=0, req_ready=0 asynchronously.
//     The first grant after release goes to req0.
//  Self-check: compare res_dst against a reference sum of the captured operands
//  and res_id against an arbiter model; fail on any mismatch or any cycle with
//  more than one req_ready bit high.

Source files
------------

// File: rtl/gpc215_arbiter.sv
// -----------------------------------------------------------------------------
// gpc215_arbiter
//   Round-robin shares one gpc215_4 generalized parallel counter between
//   NUM_REQ requesters. The winner's operands are muxed into the counter. The
//   4-bit sum is registered together with the winner's id and offered on a
//   valid/ready result port. The single result register can drain and refill
//   in the same cycle, so the block sustains one result per cycle.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous reset, active low
//   req_valid  in   NUM_REQ    per-requester operand valid
//   req_ready  out  NUM_REQ    per-requester accept (at most one bit high)
//   req_src0   in   NUM_REQ*5  weight-1 bits, requester i at [5i+4:5i]
//   req_src1   in   NUM_REQ    weight-2 bit, requester i at [i]
//   req_src2   in   NUM_REQ*2  weight-4 bits, requester i at [2i+1:2i]
//   res_valid  out  1          result register holds a valid sum
//   res_ready  in   1          downstream accepts the result
//   res_dst    out  4          popcount(src0) + 2*src1 + 4*popcount(src2)
//   res_id     out  ID_W       index of the requester that produced res_dst
// -----------------------------------------------------------------------------

// Combinational 5:1:2 -> 4 counter. The maximum is 5+2+8 = 15, so 4 bits
// never overflow.
module gpc215_4 (
  input  logic [4:0] src0,
  input  logic       src1,
  input  logic [1:0] src2,
  output logic [3:0] dst
);

  function automatic logic [3:0] sum215(input logic [4:0] s0,
                                        input logic       s1,
                                        input logic [1:0] s2);
    logic [3:0] acc;
    acc = 4'd0;
    for (int b = 0; b < 5; b++) begin
      acc = acc + {3'd0, s0[b]};
    end
    acc = acc + {2'd0, s1, 1'b0};
    for (int b = 0; b < 2; b++) begin
      acc = acc + {1'b0, s2[b], 2'b00};
    end
    return acc;
  endfunction

  // Counter output
  always_comb begin
    dst = sum215(src0, src1, src2);
  end

endmodule

module gpc215_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*5-1:0] req_src0,
  input  logic [NUM_REQ-1:0]   req_src1,
  input  logic [NUM_REQ*2-1:0] req_src2,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_dst,
  output logic [ID_W-1:0]      res_id
);

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] ptr_next_s;
  logic [ID_W-1:0] grant_s;
  logic            found_s;
  logic            can_accept_s;
  logic            xfer_s;
  int              scan_idx_s;

  logic            res_valid_r;
  logic [3:0]      res_dst_r;
  logic [ID_W-1:0] res_id_r;

  logic [4:0]      mux_src0_s;
  logic            mux_src1_s;
  logic [1:0]      mux_src2_s;
  logic [3:0]      gpc_dst_s;

  // Round-robin scan starting at ptr_r; first valid requester wins
  always_comb begin
    found_s    = 1'b0;
    grant_s    = {ID_W{1'b0}};
    scan_idx_s = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = (int'(ptr_r) + k) % NUM_REQ;
      if (!found_s && req_valid[scan_idx_s]) begin
        found_s = 1'b1;
        grant_s = ID_W'(scan_idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake: rst_n gating keeps req_ready low throughout reset, and no
  // transfer can be taken while the reset is held
  always_comb begin
    can_accept_s = !res_valid_r || res_ready;
    xfer_s       = found_s && can_accept_s && rst_n;
    req_ready    = {NUM_REQ{1'b0}};
    if (xfer_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Operand mux feeding the shared counter, plus the wrapped next pointer
  always_comb begin
    mux_src0_s = req_src0[int'(grant_s)*5 +: 5];
    mux_src1_s = req_src1[grant_s];
    mux_src2_s = req_src2[int'(grant_s)*2 +: 2];
    if (int'(grant_s) == NUM_REQ - 1) begin
      ptr_next_s = {ID_W{1'b0}};
    end else begin
      ptr_next_s = grant_s + ID_W'(1);
    end
  end

  gpc215_4 u_gpc (
    .src0 (mux_src0_s),
    .src1 (mux_src1_s),
    .src2 (mux_src2_s),
    .dst  (gpc_dst_s)
  );

  // Result register and round-robin pointer; dst/id hold after a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_dst_r   <= 4'd0;
      res_id_r    <= {ID_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
    end else if (xfer_s) begin
      res_valid_r <= 1'b1;
      res_dst_r   <= gpc_dst_s;
      res_id_r    <= grant_s;
      ptr_r       <= ptr_next_s;
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_dst   = res_dst_r;
  assign res_id    = res_id_r;

endmodule

// File: tb/tb_gpc215_arbiter.sv
module tb_gpc215_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*5-1:0] req_src0;
  logic [N-1:0]   req_src1;
  logic [N*2-1:0] req_src2;
  logic           res_valid;
  logic           res_ready;
  logic [3:0]     res_dst;
  logic [IW-1:0]  res_id;

  int tests_run    = 0;
  int tests_failed = 0;

  // Bench model: pointer, register occupancy, last loaded result, scoreboard
  int         m_ptr;
  bit         m_valid;
  logic [5:0] m_last;
  logic [5:0] sb_q[$];

  gpc215_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src0  (req_src0),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_dst   (res_dst),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] s0, input logic s1, input logic [1:0] s2);
    req_src0[i*5 +: 5] = s0;
    req_src1[i]        = s1;
    req_src2[i*2 +: 2] = s2;
  endtask

  function automatic logic [3:0] ref_sum(input int i);
    int s;
    s = $countones(req_src0[i*5 +: 5]) + 2 * int'(req_src1[i]) + 4 * $countones(req_src2[i*2 +: 2]);
    return s[3:0];
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_last  = 6'd0;
    sb_q.delete();
  endtask

  // One cycle: inputs already driven after a negedge. Check handshake,
  // update the model, cross the posedge and check the result port.
  task automatic step();
    logic [N-1:0] exp_ready;
    logic [5:0]   exp_res;
    bit           can;
    bit           found;
    int           g;
    #1;
    can   = !m_valid || res_ready;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(m_ptr + k) % N]) begin
        found = 1'b1;
        g     = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (found && can) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (m_valid && res_ready) void'(sb_q.pop_front());
    if (found && can) begin
      m_last = {2'(g), ref_sum(g)};
      sb_q.push_back(m_last);
      m_ptr   = (g + 1) % N;
      m_valid = 1'b1;
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    exp_res = (sb_q.size() > 0) ? sb_q[0] : m_last;
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_id", 32'(res_id), 32'(exp_res[5:4]));
    chk("res_dst", 32'(res_dst), 32'(exp_res[3:0]));
  endtask

  initial begin
    int exp_ids[5];
    exp_ids = '{0, 1, 2, 3, 0};

    // Reset with all requests pending: nothing may be accepted
    rst_n     = 1'b0;
    req_valid = '1;
    req_src0  = '0;
    req_src1  = '0;
    req_src2  = '0;
    res_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_dst", 32'(res_dst), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single request from req0
    set_req(0, 5'h14, 1'b1, 2'h1);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    step();
    chk("t1_dst", 32'(res_dst), 32'h8);
    chk("t1_id", 32'(res_id), 32'd0);
    req_valid = 4'b0000;
    step();
    chk("t1_drain", 32'(res_valid), 32'd0);

    // 2: arithmetic extremes through req2
    set_req(2, 5'h1f, 1'b1, 2'h3);
    req_valid = 4'b0100;
    step();
    chk("t2_max", 32'(res_dst), 32'hf);
    set_req(2, 5'h00, 1'b0, 2'h0);
    step();
    chk("t2_zero", 32'(res_dst), 32'h0);
    chk("t2_id", 32'(res_id), 32'd2);

    // Bring ptr back to 0 with a lone req3 transfer
    req_valid = 4'b1000;
    step();

    // 3: all four valid, full throughput
    for (int i = 0; i < N; i++) set_req(i, 5'(i * 7 + 3), 1'(i), 2'(i + 1));
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t3_id_seq", 32'(res_id), 32'(exp_ids[c]));
    end

    // 4: backpressure after a req1 transfer
    req_valid = 4'b0000;
    step();
    set_req(1, 5'h0d, 1'b0, 2'h3);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    step();
    chk("t4_dst", 32'(res_dst), 32'hb);
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_held_id", 32'(res_id), 32'd1);
    end
    res_ready = 1'b1;
    step();
    chk("t4_next_grant", 32'(res_id), 32'd2);

    // 5: wrap and skip with only req3 and req1, starting from ptr=2
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    step();
    chk("t5_first", 32'(res_id), 32'd3);
    step();
    chk("t5_second", 32'(res_id), 32'd1);
    req_valid = 4'b0000;
    step();
    step();
    req_valid = 4'b1111;
    step();
    chk("t5_ptr_held", 32'(res_id), 32'd2);

    // Random traffic with random backpressure and withdrawn requests
    for (int c = 0; c < 60; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      res_ready = 1'($urandom_range(0, 1));
      req_src0  = 20'($urandom);
      req_src1  = 4'($urandom);
      req_src2  = 8'($urandom);
      step();
    end

    // 6: reset while a result is pending and all requests are high
    req_valid = 4'b1111;
    res_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 32'(res_valid), 32'd0);
    chk("t6_dst", 32'(res_dst), 32'd0);
    chk("t6_id", 32'(res_id), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    step();
    chk("t6_first_grant", 32'(res_id), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
